pc_sequencer: RTL

Program-counter stage directly downstream of the branch comparator in the single-cycle RV64 datapath. Consumes the comparator's taken decision and the externally computed branch target, and holds the architectural PC. Drives a valid/ready fetch request to instruction memory and advances PC by +4 or redirects to the branch target. Buffers a redirect that resolves while fetch is stalled, and provides retire and taken-branch counters.

---
 rtl/pc_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the architectural PC, issues valid/ready fetch requests,
// applies +4 advances or branch redirects, and keeps retire/taken-branch counters.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic [63:0]      branch_target,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [63:0]      pc,
    output logic [63:0]      pc_plus4,
    output logic             misaligned,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic        pending_valid;
    logic [63:0] pending_target;
    logic        advance;
    logic        redirect;
    logic [63:0] target;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

    assign pc_plus4 = pc + 64'd4;

    // A live taken decision re-evaluates the instruction at pc, so it beats any buffered one.
    always_comb begin
        advance  = (state == RUN) && fetch_valid && fetch_ready && !stall;
        redirect = branch_taken || pending_valid;
        target   = branch_taken ? branch_target : pending_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            fetch_valid   <= 1'b0;
            misaligned    <= 1'b0;
            pending_valid <= 1'b0;
            retired_count <= '0;
            taken_count   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        retired_count <= retired_count + CNT_ONE;
                        pending_valid <= 1'b0;
                        if (redirect) begin
                            if (word_aligned(target[1:0])) begin
                                pc          <= target;
                                taken_count <= taken_count + CNT_ONE;
                            end else begin
                                misaligned  <= 1'b1;
                                state       <= HALT;
                                fetch_valid <= 1'b0;
                            end
                        end else begin
                            pc <= pc_plus4;
                        end
                    end else if (branch_taken) begin
                        pending_valid <= 1'b1;
                    end
                end
                default: begin
                    // HALT holds everything until reset
                end
            endcase
        end
    end

    // Buffered redirect address; only meaningful while pending_valid is set.
    always_ff @(posedge clk) begin
        if (state == RUN && !advance && branch_taken) begin
            pending_target <= branch_target;
        end
    end

endmodule
